// File: rtl/hub75_rx.sv
// HUB75 panel receiver: rebuilds the top/bottom pixel rows that a HUB75 driver
// shifts out serially and presents each row on its latch strobe.

// One colour half of the panel: a COLS-deep, 3-bit-wide shift chain plus
// the row register it is copied into on a latch.
module hub75_rx_lane #(
  parameter int COLS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                latch_en,
  input  logic [2:0]          din,
  output logic [3*COLS-1:0]   row
);
  logic [3*COLS-1:0] sh_q;
  logic [3*COLS-1:0] sh_d;

  // Column 0 takes the new pixel; every other column takes its lower neighbour.
  always_comb begin
    sh_d = sh_q;
    if (shift_en) sh_d = {sh_q[3*COLS-4:0], din};
  end

  // The row register copies the post-shift value, so a coincident shift is included.
  // The chain itself is never cleared by a latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
      row  <= '0;
    end else begin
      sh_q <= sh_d;
      if (latch_en) row <= sh_d;
    end
  end
endmodule

module hub75_rx #(
  parameter int COLS = 32,
  parameter int ROWS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk,
  input  logic                      blank,
  input  logic                      latch,
  input  logic [2:0]                rgb_top,
  input  logic [2:0]                rgb_bot,
  input  logic [$clog2(ROWS)-1:0]   addr,
  output logic [3*COLS-1:0]         row_top,
  output logic [3*COLS-1:0]         row_bot,
  output logic [$clog2(ROWS)-1:0]   row_addr,
  output logic                      display_on,
  output logic                      row_valid,
  output logic                      frame_done,
  output logic [$clog2(COLS)+1:0]   shift_cnt,
  output logic                      err_count,
  output logic                      err_unblank
);
  localparam int AW        = $clog2(ROWS);
  localparam int CW        = $clog2(COLS) + 2;
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCHED} state_t;

  state_t state_q, state_d;

  logic sclk_q, latch_q;
  logic sclk_rise, latch_rise;
  logic [CW-1:0] cnt_pre;

  logic [NUM_LANES-1:0][2:0]        lane_din;
  logic [NUM_LANES-1:0][3*COLS-1:0] lane_row;

  assign sclk_rise  = sclk & ~sclk_q;
  assign latch_rise = latch & ~latch_q;

  assign lane_din = {rgb_bot, rgb_top};
  assign row_top  = lane_row[0];
  assign row_bot  = lane_row[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      hub75_rx_lane #(.COLS(COLS)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .shift_en (sclk_rise),
        .latch_en (latch_rise),
        .din      (lane_din[gi]),
        .row      (lane_row[gi])
      );
    end
  endgenerate

  // Count including this cycle's shift; this is what the latch error check sees.
  always_comb begin
    cnt_pre = shift_cnt;
    if (sclk_rise && shift_cnt != {CW{1'b1}}) cnt_pre = shift_cnt + 1'b1;
  end

  // Edge detectors, shift counter, latched address, pulses and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      shift_cnt   <= '0;
      row_addr    <= '0;
      row_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err_count   <= 1'b0;
      err_unblank <= 1'b0;
      display_on  <= 1'b0;
    end else begin
      sclk_q     <= sclk;
      latch_q    <= latch;
      display_on <= ~blank;
      row_valid  <= latch_rise;
      frame_done <= latch_rise && (addr == AW'(ROWS - 1));
      if (latch_rise) begin
        shift_cnt <= '0;
        row_addr  <= addr;
        if (cnt_pre != CW'(COLS)) err_count   <= 1'b1;
        if (!blank)               err_unblank <= 1'b1;
      end else begin
        shift_cnt <= cnt_pre;
      end
    end
  end

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Protocol tracking: a held latch level parks in LATCHED without re-latching.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (latch_rise)     state_d = LATCHED;
        else if (sclk_rise) state_d = SHIFT;
      end
      SHIFT: begin
        if (latch_rise) state_d = LATCHED;
      end
      LATCHED: begin
        if (!latch) state_d = sclk_rise ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: table of row scenarios, hand-written
// corner sequences and a random phase, all against a column-array model.
module tb_hub75_rx;
  localparam int COLS = 32;
  localparam int ROWS = 8;
  localparam int AW   = 3;
  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, sclk, blank, latch;
  logic [2:0] rgb_top, rgb_bot;
  logic [AW-1:0] addr;
  logic [3*COLS-1:0] row_top, row_bot;
  logic [AW-1:0] row_addr;
  logic display_on, row_valid, frame_done, err_count, err_unblank;
  logic [CW-1:0] shift_cnt;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int fd_addr = -1;
  int fd_valid = 0;

  hub75_rx #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .blank(blank), .latch(latch),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot), .addr(addr),
    .row_top(row_top), .row_bot(row_bot), .row_addr(row_addr),
    .display_on(display_on), .row_valid(row_valid), .frame_done(frame_done),
    .shift_cnt(shift_cnt), .err_count(err_count), .err_unblank(err_unblank)
  );

  always #5 clk = ~clk;

  // Reference model: pixels kept as an array of columns.
  logic [2:0] m_top [COLS];
  logic [2:0] m_bot [COLS];
  logic [2:0] m_rtop[COLS];
  logic [2:0] m_rbot[COLS];
  int m_cnt, m_addr;
  bit m_valid, m_frame, m_ec, m_eu, m_disp, m_sq, m_lq;

  task automatic model_clk();
    bit sr, lr;
    int c1;
    if (reset) begin
      for (int c = 0; c < COLS; c++) begin
        m_top[c] = 0; m_bot[c] = 0; m_rtop[c] = 0; m_rbot[c] = 0;
      end
      m_cnt = 0; m_addr = 0; m_valid = 0; m_frame = 0; m_ec = 0; m_eu = 0;
      m_disp = 0; m_sq = 0; m_lq = 0;
      return;
    end
    sr = sclk && !m_sq;
    lr = latch && !m_lq;
    m_sq = sclk; m_lq = latch; m_disp = !blank;
    m_valid = 0; m_frame = 0;
    if (sr) begin
      for (int c = COLS - 1; c > 0; c--) begin
        m_top[c] = m_top[c-1]; m_bot[c] = m_bot[c-1];
      end
      m_top[0] = rgb_top; m_bot[0] = rgb_bot;
    end
    c1 = sr ? ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1) : m_cnt;
    if (lr) begin
      for (int c = 0; c < COLS; c++) begin
        m_rtop[c] = m_top[c]; m_rbot[c] = m_bot[c];
      end
      m_addr = int'(addr); m_valid = 1; m_frame = (int'(addr) == ROWS - 1);
      if (c1 != COLS) m_ec = 1;
      if (!blank) m_eu = 1;
      m_cnt = 0;
    end else begin
      m_cnt = c1;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [3*COLS-1:0] et, eb;
    for (int c = 0; c < COLS; c++) begin
      et[3*c +: 3] = m_rtop[c];
      eb[3*c +: 3] = m_rbot[c];
    end
    check("model row_top", 128'(row_top), 128'(et));
    check("model row_bot", 128'(row_bot), 128'(eb));
    check("model row_addr", 128'(row_addr), 128'(m_addr));
    check("model shift_cnt", 128'(shift_cnt), 128'(m_cnt));
    check("model row_valid", 128'(row_valid), 128'(m_valid));
    check("model frame_done", 128'(frame_done), 128'(m_frame));
    check("model err_count", 128'(err_count), 128'(m_ec));
    check("model err_unblank", 128'(err_unblank), 128'(m_eu));
    check("model display_on", 128'(display_on), 128'(m_disp));
  endtask

  task automatic step(input bit s, input bit l, input bit b,
                      input logic [2:0] t, input logic [2:0] bo, input logic [AW-1:0] a);
    sclk = s; latch = l; blank = b; rgb_top = t; rgb_bot = bo; addr = a;
    @(posedge clk);
    model_clk();
    #1;
    check_model();
    if (frame_done) begin
      fd_cnt++; fd_addr = int'(row_addr); fd_valid = int'(row_valid);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 1, 3'd0, 3'd0, '0);
    reset = 1'b0;
  endtask

  // n full sclk pulses; pat selects the even-column 001 pattern on top.
  task automatic shift_n(input int n, input bit b, input logic [AW-1:0] a, input bit pat);
    logic [2:0] t, bo;
    for (int i = 0; i < n; i++) begin
      t  = pat ? ((i % 2 == 0) ? 3'b001 : 3'b000) : 3'($urandom);
      bo = 3'($urandom);
      step(1, 0, b, t, bo, a);
      step(0, 0, b, t, bo, a);
    end
  endtask

  typedef struct {
    bit rst; int nshift; bit blank; logic [AW-1:0] addr; bit coin; bit pat;
    bit exp_frame; bit exp_ec; bit exp_eu;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [3*COLS-1:0] expv;
    int nv;
    reset = 1'b1; sclk = 0; latch = 0; blank = 1; rgb_top = 0; rgb_bot = 0; addr = 0;

    vecs[0] = '{1, 32, 1, 3'd3, 0, 1, 0, 0, 0};
    vecs[1] = '{0, 32, 1, 3'd7, 0, 0, 1, 0, 0};
    vecs[2] = '{1, 31, 1, 3'd2, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 32, 1, 3'd5, 0, 0, 0, 1, 0};
    vecs[4] = '{1, 32, 0, 3'd1, 0, 0, 0, 0, 1};
    vecs[5] = '{1, 32, 1, 3'd4, 1, 0, 0, 0, 0};
    vecs[6] = '{1, 33, 1, 3'd6, 0, 0, 0, 1, 0};

    // Reset state.
    do_reset();
    check("reset row_top", 128'(row_top), 128'(0));
    check("reset display_on", 128'(display_on), 128'(0));
    check("reset shift_cnt", 128'(shift_cnt), 128'(0));

    // Table of row scenarios.
    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      shift_n(vecs[k].nshift - int'(vecs[k].coin), vecs[k].blank, vecs[k].addr, vecs[k].pat);
      step(vecs[k].coin, 1, vecs[k].blank, 3'b101, 3'b010, vecs[k].addr);
      check($sformatf("v%0d row_valid", k), 128'(row_valid), 128'(1));
      check($sformatf("v%0d row_addr", k), 128'(row_addr), 128'(vecs[k].addr));
      check($sformatf("v%0d shift_cnt", k), 128'(shift_cnt), 128'(0));
      check($sformatf("v%0d frame_done", k), 128'(frame_done), 128'(vecs[k].exp_frame));
      check($sformatf("v%0d err_count", k), 128'(err_count), 128'(vecs[k].exp_ec));
      check($sformatf("v%0d err_unblank", k), 128'(err_unblank), 128'(vecs[k].exp_eu));
      if (vecs[k].pat) begin
        for (int c = 0; c < COLS; c++) expv[3*c +: 3] = ((COLS - 1 - c) % 2 == 0) ? 3'b001 : 3'b000;
        check("pattern row_top", 128'(row_top), 128'(expv));
      end
      if (vecs[k].coin) check("coincident col0", 128'(row_top[2:0]), 128'(3'b101));
      step(0, 0, vecs[k].blank, 3'd0, 3'd0, vecs[k].addr);
      check($sformatf("v%0d row_valid drop", k), 128'(row_valid), 128'(0));
    end

    // Full frame: exactly one frame_done, on the addr=7 row.
    do_reset();
    fd_cnt = 0; fd_addr = -1; fd_valid = 0;
    for (int a = 0; a < ROWS; a++) begin
      shift_n(COLS, 1, AW'(a), 0);
      step(0, 1, 1, 3'd0, 3'd0, AW'(a));
      step(0, 0, 1, 3'd0, 3'd0, AW'(a));
    end
    check("frame_done count", 128'(fd_cnt), 128'(1));
    check("frame_done addr", 128'(fd_addr), 128'(7));
    check("frame_done with row_valid", 128'(fd_valid), 128'(1));
    check("frame err_count", 128'(err_count), 128'(0));

    // Reset after 10 shifts, then a clean row.
    shift_n(10, 1, 3'd2, 0);
    do_reset();
    check("midreset row_top", 128'(row_top), 128'(0));
    check("midreset row_bot", 128'(row_bot), 128'(0));
    check("midreset row_addr", 128'(row_addr), 128'(0));
    check("midreset shift_cnt", 128'(shift_cnt), 128'(0));
    check("midreset flags", 128'({row_valid, frame_done, err_count, err_unblank, display_on}), 128'(0));
    shift_n(COLS, 1, 3'd2, 0);
    step(0, 1, 1, 3'd0, 3'd0, 3'd2);
    check("post-reset row_valid", 128'(row_valid), 128'(1));
    check("post-reset err_count", 128'(err_count), 128'(0));

    // Latch held high: shifts still count, no re-latch.
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 3'($urandom), 3'($urandom), 3'd2);
      nv += int'(row_valid);
      step(0, 1, 1, 3'd0, 3'd0, 3'd2);
      nv += int'(row_valid);
    end
    check("held latch no relatch", 128'(nv), 128'(0));
    check("held latch shift_cnt", 128'(shift_cnt), 128'(5));
    step(0, 0, 1, 3'd0, 3'd0, 3'd2);

    // Counter saturation.
    shift_n(130, 1, 3'd0, 0);
    check("shift_cnt saturate", 128'(shift_cnt), 128'(CMAX));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom), AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
